// File: rtl/inst_sram_responder.sv
// Instruction-memory responder on the sram-like req/addr_ok/data_ok fetch handshake.
// Returns words in order after a fixed latency, with a loader write port for preloading.
module inst_sram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic [31:0]       addr,
    output logic              addr_ok,
    output logic [31:0]       rdata,
    output logic              data_ok,
    input  logic              stall_in,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [LATENCY-1:0] vld;
    logic [31:0]       dat [0:LATENCY-1];
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic              unused_addr_bits;

    assign idx              = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign data_ok = vld[LATENCY-1];
    assign rdata   = dat[LATENCY-1];
    assign addr_ok = !stall_in && resetn && ((count < CW'(DEPTH)) || data_ok);
    assign accept  = req && addr_ok;

    // The loader ignores reset so the image can be written while the core is held.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_wdata;
        end
    end

    // Data only advances behind a valid bit, so the last stage holds the previous return.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat[i] <= 32'h0;
            end
        end else begin
            vld[0] <= accept;
            if (accept) begin
                dat[0] <= mem[idx];
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= count + CW'(accept) - CW'(data_ok);
        end
    end
endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench for inst_sram_responder: a LATENCY=2/DEPTH=2 instance and a
// LATENCY=3/DEPTH=1 instance share clock, reset and loader.
module tb_inst_sram_responder;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req, req3;
    logic [31:0] addr, addr3;
    logic        stall_in, stall3;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        addr_ok, data_ok, addr_ok3, data_ok3;
    logic [31:0] rdata, rdata3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_sram_responder #(.ADDR_W(12), .LATENCY(2), .DEPTH(2)) dut (
        .clk(clk), .resetn(resetn), .req(req), .addr(addr), .addr_ok(addr_ok),
        .rdata(rdata), .data_ok(data_ok), .stall_in(stall_in),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    inst_sram_responder #(.ADDR_W(12), .LATENCY(3), .DEPTH(1)) dut3 (
        .clk(clk), .resetn(resetn), .req(req3), .addr(addr3), .addr_ok(addr_ok3),
        .rdata(rdata3), .data_ok(data_ok3), .stall_in(stall3),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [31:0] d);
        tick();
        ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; req3 = 1'b0; addr = 32'h0; addr3 = 32'h0;
        stall_in = 1'b0; stall3 = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = 32'h0;

        load(12'd0, 32'h11111111);
        load(12'd1, 32'h22222222);
        load(12'd2, 32'h33333333);
        load(12'd3, 32'h44444444);
        load(12'd5, 32'hAAAA0000);
        tick();
        ld_we = 1'b0;
        settle();
        check("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
        check("rst_data_ok", {31'b0, data_ok}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr_ok3", {31'b0, addr_ok3}, 32'd0);
        check("rst_rdata3", rdata3, 32'h0);

        // Back-to-back fetch stream, first accept in the first cycle out of reset
        tick(); resetn = 1'b1; req = 1'b1; addr = 32'hbfc00000; settle();
        check("s0_addr_ok", {31'b0, addr_ok}, 32'd1);
        check("s0_data_ok", {31'b0, data_ok}, 32'd0);
        tick(); addr = 32'hbfc00004; settle();
        check("s1_addr_ok", {31'b0, addr_ok}, 32'd1);
        check("s1_data_ok", {31'b0, data_ok}, 32'd0);
        tick(); addr = 32'hbfc00008; settle();
        check("s2_addr_ok", {31'b0, addr_ok}, 32'd1);
        check("s2_data_ok", {31'b0, data_ok}, 32'd1);
        check("s2_rdata", rdata, 32'h11111111);
        tick(); addr = 32'hbfc0000c; settle();
        check("s3_addr_ok", {31'b0, addr_ok}, 32'd1);
        check("s3_data_ok", {31'b0, data_ok}, 32'd1);
        check("s3_rdata", rdata, 32'h22222222);
        tick(); req = 1'b0; settle();
        check("s4_data_ok", {31'b0, data_ok}, 32'd1);
        check("s4_rdata", rdata, 32'h33333333);
        tick(); settle();
        check("s5_data_ok", {31'b0, data_ok}, 32'd1);
        check("s5_rdata", rdata, 32'h44444444);
        tick(); settle();
        check("s6_data_ok", {31'b0, data_ok}, 32'd0);
        check("s6_rdata_hold", rdata, 32'h44444444);

        // DEPTH=1, LATENCY=3: accepts only every third cycle
        for (int k = 0; k < 9; k++) begin
            tick(); req3 = 1'b1; addr3 = k * 4; settle();
            check($sformatf("d1_addr_ok_%0d", k), {31'b0, addr_ok3}, (k % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("d1_data_ok_%0d", k), {31'b0, data_ok3},
                  (k >= 3 && k % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("d1_count_le1_%0d", k), {31'b0, (dut3.count <= 1)}, 32'd1);
            if (k == 3) check("d1_rdata_k3", rdata3, 32'h11111111);
            if (k == 6) check("d1_rdata_k6", rdata3, 32'h44444444);
        end
        tick(); req3 = 1'b0;

        // Loader write colliding with a read of the same word
        tick(); req = 1'b1; addr = 32'h14; ld_we = 1'b1; ld_addr = 12'd5; ld_wdata = 32'hBBBB0000; settle();
        check("wr_addr_ok", {31'b0, addr_ok}, 32'd1);
        tick(); ld_we = 1'b0; settle();
        check("wr_addr_ok2", {31'b0, addr_ok}, 32'd1);
        tick(); req = 1'b0; settle();
        check("wr_old_data_ok", {31'b0, data_ok}, 32'd1);
        check("wr_old_rdata", rdata, 32'hAAAA0000);
        tick(); settle();
        check("wr_new_data_ok", {31'b0, data_ok}, 32'd1);
        check("wr_new_rdata", rdata, 32'hBBBB0000);

        // Reset with two requests in flight
        tick(); req = 1'b1; addr = 32'h0; settle();
        check("rs_acc0", {31'b0, addr_ok}, 32'd1);
        tick(); addr = 32'h4; settle();
        check("rs_acc1", {31'b0, addr_ok}, 32'd1);
        tick(); resetn = 1'b0; req = 1'b0; settle();
        check("rs_addr_ok_low", {31'b0, addr_ok}, 32'd0);
        tick(); resetn = 1'b1; req = 1'b1; addr = 32'h4; settle();
        check("rs_first_accept", {31'b0, addr_ok}, 32'd1);
        check("rs_data_ok0", {31'b0, data_ok}, 32'd0);
        check("rs_rdata0", rdata, 32'h0);
        tick(); req = 1'b0; settle();
        check("rs_data_ok1", {31'b0, data_ok}, 32'd0);
        check("rs_rdata1", rdata, 32'h0);
        tick(); settle();
        check("rs_fresh_data_ok", {31'b0, data_ok}, 32'd1);
        check("rs_fresh_rdata", rdata, 32'h22222222);

        // Backpressure while two returns are pending
        tick(); req = 1'b1; addr = 32'h8; settle();
        check("st_acc0", {31'b0, addr_ok}, 32'd1);
        tick(); addr = 32'hc; settle();
        check("st_acc1", {31'b0, addr_ok}, 32'd1);
        tick(); stall_in = 1'b1; settle();
        check("st0_addr_ok", {31'b0, addr_ok}, 32'd0);
        check("st0_data_ok", {31'b0, data_ok}, 32'd1);
        check("st0_rdata", rdata, 32'h33333333);
        tick(); settle();
        check("st1_addr_ok", {31'b0, addr_ok}, 32'd0);
        check("st1_data_ok", {31'b0, data_ok}, 32'd1);
        check("st1_rdata", rdata, 32'h44444444);
        tick(); settle();
        check("st2_addr_ok", {31'b0, addr_ok}, 32'd0);
        check("st2_data_ok", {31'b0, data_ok}, 32'd0);

        // Stall release with an address whose ignored bits are set
        tick(); stall_in = 1'b0; addr = 32'h00004001; settle();
        check("st_release_addr_ok", {31'b0, addr_ok}, 32'd1);
        tick(); req = 1'b0; settle();
        check("ign_data_ok0", {31'b0, data_ok}, 32'd0);
        tick(); settle();
        check("ign_data_ok", {31'b0, data_ok}, 32'd1);
        check("ign_rdata", rdata, 32'h11111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
